// File: rtl/wb_rr_interconnect.sv
// Shared-bus Wishbone interconnect: round-robin arbitration across NUM_M masters,
// top-nibble address decode to NUM_S slaves, error termination for unmapped or hung slaves.
module wb_rr_interconnect #(
    parameter int NUM_M   = 2,
    parameter int NUM_S   = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255,
    localparam int SW     = DW / 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_M-1:0]    m_cyc_i,
    input  logic [NUM_M-1:0]    m_stb_i,
    input  logic [NUM_M-1:0]    m_we_i,
    input  logic [NUM_M*SW-1:0] m_sel_i,
    input  logic [NUM_M*AW-1:0] m_addr_i,
    input  logic [NUM_M*DW-1:0] m_data_i,
    output logic [DW-1:0]       m_data_o,
    output logic [NUM_M-1:0]    m_ack_o,
    output logic [NUM_M-1:0]    m_err_o,
    output logic [NUM_M-1:0]    m_rty_o,
    output logic [NUM_S-1:0]    s_cyc_o,
    output logic [NUM_S-1:0]    s_stb_o,
    output logic                s_we_o,
    output logic [SW-1:0]       s_sel_o,
    output logic [AW-1:0]       s_addr_o,
    output logic [DW-1:0]       s_data_o,
    input  logic [NUM_S*DW-1:0] s_data_i,
    input  logic [NUM_S-1:0]    s_ack_i,
    input  logic [NUM_S-1:0]    s_err_i,
    input  logic [NUM_S-1:0]    s_rty_i,
    output logic [NUM_M-1:0]    gnt_o,
    output logic                fsm_state
);

    localparam int MW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [MW-1:0]     owner, last, winner;
    logic [NUM_M-1:0]  gnt_q, gnt_nxt;
    logic [CW-1:0]     wait_cnt;
    logic              stb_prev, unmap_err;
    logic              granted, owner_cyc, owner_stb;
    logic [3:0]        idx;
    logic              mapped, err_pend;
    logic              sl_ack, sl_err, sl_rty;
    logic [DW-1:0]     sl_data;
    logic              term_ack, term_err, term_rty;

    assign granted   = (state == GRANT);
    assign owner_cyc = granted & m_cyc_i[owner];
    assign owner_stb = granted & m_stb_i[owner];
    assign gnt_o     = gnt_q;
    assign fsm_state = state;

    // Round-robin search begins just after the previous owner.
    always_comb begin
        logic          found;
        logic [MW-1:0] cand;
        winner = last;
        found  = 1'b0;
        for (int i = 1; i <= NUM_M; i++) begin
            cand = MW'((int'(last) + i) % NUM_M);
            if (!found && m_cyc_i[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
        for (int i = 0; i < NUM_M; i++) begin
            gnt_nxt[i] = (winner == MW'(i));
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|m_cyc_i) state_nxt = GRANT;
            GRANT:   if (!owner_cyc) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_addr_o = '0;
        s_data_o = '0;
        if (granted) begin
            s_we_o   = m_we_i[owner];
            s_sel_o  = m_sel_i[owner*SW +: SW];
            s_addr_o = m_addr_i[owner*AW +: AW];
            s_data_o = m_data_i[owner*DW +: DW];
        end
    end

    assign idx      = s_addr_o[AW-1 -: 4];
    assign mapped   = granted && (int'(idx) < NUM_S);
    assign err_pend = owner_stb && (wait_cnt == TMAX);

    // The timeout cycle withdraws the strobe so the slave cannot start late.
    always_comb begin
        s_cyc_o = '0;
        s_stb_o = '0;
        sl_ack  = 1'b0;
        sl_err  = 1'b0;
        sl_rty  = 1'b0;
        sl_data = '0;
        for (int i = 0; i < NUM_S; i++) begin
            if (granted && idx == 4'(i)) begin
                s_cyc_o[i] = owner_cyc;
                s_stb_o[i] = owner_stb & ~err_pend;
                sl_ack     = s_ack_i[i];
                sl_err     = s_err_i[i];
                sl_rty     = s_rty_i[i];
                sl_data    = s_data_i[i*DW +: DW];
            end
        end
    end

    assign term_ack = owner_stb & sl_ack;
    assign term_rty = owner_stb & sl_rty;
    assign term_err = owner_stb & (sl_err | ((err_pend | unmap_err) & ~sl_ack));
    assign m_data_o = sl_data;

    always_comb begin
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        if (granted) begin
            m_ack_o[owner] = term_ack;
            m_err_o[owner] = term_err;
            m_rty_o[owner] = term_rty;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt_q     <= '0;
            owner     <= '0;
            last      <= MW'(NUM_M - 1);
            wait_cnt  <= '0;
            stb_prev  <= 1'b0;
            unmap_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == GRANT) begin
                owner <= winner;
                last  <= winner;
                gnt_q <= gnt_nxt;
            end else if (state_nxt == IDLE) begin
                gnt_q <= '0;
            end
            if (!owner_stb || term_ack || term_err || term_rty) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + CW'(1);
            end
            stb_prev  <= owner_stb;
            // Unmapped error fires once, on the cycle after the strobe first appears.
            unmap_err <= owner_stb & ~mapped & ~stb_prev;
        end
    end

endmodule
